// File: rtl/dds_phase_gen.sv
// Phase accumulator and tuning-word generator for the DDS sine look-up stage.
// It supports a fixed FTW or a linear upward FTW sweep, either single or repeating.
module dds_phase_gen #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 10,
  parameter int DWELL_W = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               run,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_mode,
  input  logic [ACC_W-1:0]   cfg_ftw_start,
  input  logic [ACC_W-1:0]   cfg_ftw_stop,
  input  logic [ACC_W-1:0]   cfg_ftw_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [ACC_W-1:0]   cfg_phase_off,
  input  logic               cfg_phase_rst,
  output logic [ADDR_W-1:0]  phase_out,
  output logic               phase_valid,
  output logic               sweep_done,
  output logic               busy,
  output logic [1:0]         dbg_state,
  output logic [ACC_W-1:0]   dbg_ftw
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIXED = 2'd1,
    S_SWEEP = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_cfg_ready;
  logic                r_busy;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_ftw;
  logic [ACC_W-1:0]    r_off;
  logic [ACC_W-1:0]    r_start;
  logic [ACC_W-1:0]    r_stop;
  logic [ACC_W-1:0]    r_step;
  logic [DWELL_W-1:0]  r_dwell;
  logic [DWELL_W-1:0]  r_dwell_cnt;
  logic                r_repeat;
  logic                r_at_stop;
  logic [ADDR_W-1:0]   r_phase_out;
  logic                r_phase_valid;
  logic                r_sweep_done;

  state_t              w_next_state;
  logic                w_accept;
  logic                w_active;
  logic                w_is_sweep;
  logic                w_start_ge_stop;
  logic                w_dwell_end;
  logic [ACC_W:0]      w_sum;
  logic [ACC_W-1:0]    w_step_ftw;
  logic [ACC_W-1:0]    w_phase_sum;

  // Config handshake: a transfer happens on a rising edge where cfg_valid and
  // cfg_ready are both high; cfg_ready is low only while a sweep is running.
  assign w_accept        = cfg_valid && r_cfg_ready;
  assign w_active        = run && (r_state != S_IDLE) && !w_accept;
  assign w_is_sweep      = ((cfg_mode == 2'd1) || (cfg_mode == 2'd2)) && (cfg_ftw_step != '0);
  assign w_start_ge_stop = cfg_ftw_start >= cfg_ftw_stop;
  assign w_dwell_end     = r_dwell_cnt == r_dwell;
  // One bit wider so an overflowing step saturates to the stop word.
  assign w_sum           = {1'b0, r_ftw} + {1'b0, r_step};
  assign w_step_ftw      = (w_sum >= {1'b0, r_stop}) ? r_stop : w_sum[ACC_W-1:0];
  assign w_phase_sum     = r_acc + r_off;

  always_comb begin
    w_next_state = r_state;
    if (w_accept) begin
      if (!w_is_sweep)
        w_next_state = S_FIXED;
      else if (w_start_ge_stop && (cfg_mode == 2'd1))
        w_next_state = S_HOLD;
      else
        w_next_state = S_SWEEP;
    end else if (w_active && (r_state == S_SWEEP) && w_dwell_end && !r_at_stop &&
                 (w_step_ftw == r_stop) && !r_repeat) begin
      w_next_state = S_HOLD;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= S_IDLE;
      r_cfg_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_acc         <= '0;
      r_ftw         <= '0;
      r_off         <= '0;
      r_start       <= '0;
      r_stop        <= '0;
      r_step        <= '0;
      r_dwell       <= '0;
      r_dwell_cnt   <= '0;
      r_repeat      <= 1'b0;
      r_at_stop     <= 1'b0;
      r_phase_out   <= '0;
      r_phase_valid <= 1'b0;
      r_sweep_done  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_busy       <= (w_next_state == S_FIXED) || (w_next_state == S_SWEEP);
      r_cfg_ready  <= (w_next_state != S_SWEEP);
      r_sweep_done <= 1'b0;
      if (w_accept) begin
        r_ftw         <= (w_is_sweep && w_start_ge_stop) ? cfg_ftw_stop : cfg_ftw_start;
        r_off         <= cfg_phase_off;
        r_start       <= cfg_ftw_start;
        r_stop        <= cfg_ftw_stop;
        r_step        <= cfg_ftw_step;
        r_dwell       <= cfg_dwell;
        r_dwell_cnt   <= '0;
        r_repeat      <= (cfg_mode == 2'd2);
        r_at_stop     <= w_is_sweep && w_start_ge_stop;
        r_sweep_done  <= w_is_sweep && w_start_ge_stop;
        r_phase_valid <= 1'b0;
        if (cfg_phase_rst)
          r_acc <= '0;
      end else if (w_active) begin
        r_phase_out   <= w_phase_sum[ACC_W-1 -: ADDR_W];
        r_acc         <= r_acc + r_ftw;
        r_phase_valid <= 1'b1;
        if (r_state == S_SWEEP) begin
          if (w_dwell_end) begin
            r_dwell_cnt <= '0;
            if (r_at_stop) begin
              // Repeating sweep: one full dwell at stop, then restart.
              if (r_start >= r_stop) begin
                r_ftw        <= r_stop;
                r_sweep_done <= 1'b1;
              end else begin
                r_ftw     <= r_start;
                r_at_stop <= 1'b0;
              end
            end else begin
              r_ftw <= w_step_ftw;
              if (w_step_ftw == r_stop) begin
                r_sweep_done <= 1'b1;
                r_at_stop    <= 1'b1;
              end
            end
          end else begin
            r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
          end
        end
      end else begin
        r_phase_valid <= 1'b0;
      end
    end
  end

  assign cfg_ready   = r_cfg_ready;
  assign busy        = r_busy;
  assign phase_out   = r_phase_out;
  assign phase_valid = r_phase_valid;
  assign sweep_done  = r_sweep_done;
  assign dbg_state   = r_state;
  assign dbg_ftw     = r_ftw;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed self-checking bench for dds_phase_gen: fixed, offset, retune,
// single/repeating sweep, freeze, reset and sweep edge cases.
module tb_dds_phase_gen;

  localparam int ACC_W   = 32;
  localparam int ADDR_W  = 10;
  localparam int DWELL_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIXED = 2'd1;
  localparam logic [1:0] ST_SWEEP = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic               CLK;
  logic               RST_N;
  logic               run;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_mode;
  logic [ACC_W-1:0]   cfg_ftw_start;
  logic [ACC_W-1:0]   cfg_ftw_stop;
  logic [ACC_W-1:0]   cfg_ftw_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [ACC_W-1:0]   cfg_phase_off;
  logic               cfg_phase_rst;
  logic [ADDR_W-1:0]  phase_out;
  logic               phase_valid;
  logic               sweep_done;
  logic               busy;
  logic [1:0]         dbg_state;
  logic [ACC_W-1:0]   dbg_ftw;

  int n_checks = 0;
  int n_fail   = 0;

  dds_phase_gen #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .run           (run),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_mode      (cfg_mode),
    .cfg_ftw_start (cfg_ftw_start),
    .cfg_ftw_stop  (cfg_ftw_stop),
    .cfg_ftw_step  (cfg_ftw_step),
    .cfg_dwell     (cfg_dwell),
    .cfg_phase_off (cfg_phase_off),
    .cfg_phase_rst (cfg_phase_rst),
    .phase_out     (phase_out),
    .phase_valid   (phase_valid),
    .sweep_done    (sweep_done),
    .busy          (busy),
    .dbg_state     (dbg_state),
    .dbg_ftw       (dbg_ftw)
  );

  // Clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_cfg(input logic [1:0] mode, input logic [31:0] start,
                          input logic [31:0] stop, input logic [31:0] step,
                          input logic [15:0] dwell, input logic [31:0] off,
                          input logic prst);
    cfg_mode      = mode;
    cfg_ftw_start = start;
    cfg_ftw_stop  = stop;
    cfg_ftw_step  = step;
    cfg_dwell     = dwell;
    cfg_phase_off = off;
    cfg_phase_rst = prst;
    cfg_valid     = 1'b1;
    tick();
    cfg_valid     = 1'b0;
  endtask

  logic [31:0] ss_ftw [6] = '{32'h100, 32'h200, 32'h200, 32'h300, 32'h300, 32'h400};
  logic [31:0] rp_ftw [9] = '{32'h100, 32'h200, 32'h250, 32'h0, 32'h100, 32'h200,
                              32'h250, 32'h0, 32'h100};

  initial begin
    RST_N = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'd0;
    cfg_ftw_start = '0; cfg_ftw_stop = '0; cfg_ftw_step = '0; cfg_dwell = '0;
    cfg_phase_off = '0; cfg_phase_rst = 1'b0;
    tick();
    tick();
    check("rst_phase_out", phase_out, 0);
    check("rst_valid", phase_valid, 0);
    check("rst_done", sweep_done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_state", dbg_state, ST_IDLE);
    RST_N = 1'b1;
    run   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("noconf_valid", phase_valid, 0);
      check("noconf_state", dbg_state, ST_IDLE);
    end

    // Fixed mode with wrap of the 10-bit address
    send_cfg(2'd0, 32'h0100_0000, 32'h0, 32'h0, 16'd0, 32'h0, 1'b1);
    check("fx_accept_valid", phase_valid, 0);
    check("fx_busy", busy, 1);
    check("fx_ready", cfg_ready, 1);
    check("fx_state", dbg_state, ST_FIXED);
    for (int k = 0; k < 260; k++) begin
      tick();
      check("fx_phase", phase_out, (k * 4) % 1024);
      check("fx_valid", phase_valid, 1);
      check("fx_done", sweep_done, 0);
    end

    // Offset, then phase-continuous retune
    send_cfg(2'd0, 32'h0100_0000, 32'h0, 32'h0, 16'd0, 32'h8000_0000, 1'b1);
    tick(); check("off_phase0", phase_out, 512);
    tick(); check("off_phase1", phase_out, 516);
    tick(); check("off_phase2", phase_out, 520);
    send_cfg(2'd0, 32'h0200_0000, 32'h0, 32'h0, 16'd0, 32'h8000_0000, 1'b0);
    check("rt_accept_valid", phase_valid, 0);
    check("rt_hold_phase", phase_out, 520);
    tick(); check("rt_phase0", phase_out, 524);
    tick(); check("rt_phase1", phase_out, 532);
    tick(); check("rt_phase2", phase_out, 540);

    // Asynchronous reset asserted mid-cycle
    #3;
    RST_N = 1'b0;
    #1;
    check("arst_phase_out", phase_out, 0);
    check("arst_valid", phase_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", cfg_ready, 1);
    check("arst_state", dbg_state, ST_IDLE);
    check("arst_ftw", dbg_ftw, 0);
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_noconf_valid", phase_valid, 0);
    end

    // Single sweep with a 5-cycle freeze in the middle of a dwell period
    send_cfg(2'd1, 32'h100, 32'h400, 32'h100, 16'd1, 32'h0, 1'b1);
    check("ss_ftw_start", dbg_ftw, 32'h100);
    check("ss_state", dbg_state, ST_SWEEP);
    check("ss_ready", cfg_ready, 0);
    check("ss_busy", busy, 1);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        run = 1'b0;
        for (int j = 0; j < 5; j++) begin
          tick();
          check("frz_valid", phase_valid, 0);
          check("frz_ftw", dbg_ftw, 32'h200);
          check("frz_state", dbg_state, ST_SWEEP);
        end
        run = 1'b1;
      end
      tick();
      check("ss_ftw", dbg_ftw, ss_ftw[i]);
      check("ss_done", sweep_done, (i == 5));
      check("ss_valid", phase_valid, 1);
    end
    check("ss_end_state", dbg_state, ST_HOLD);
    check("ss_end_ready", cfg_ready, 1);
    check("ss_end_busy", busy, 0);
    tick();
    check("hold_done", sweep_done, 0);
    check("hold_ftw", dbg_ftw, 32'h400);
    check("hold_valid", phase_valid, 1);

    // Repeating sweep with saturation; offered config must be ignored
    send_cfg(2'd2, 32'h0, 32'h250, 32'h100, 16'd0, 32'h0, 1'b1);
    check("rp_ftw_start", dbg_ftw, 32'h0);
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        cfg_mode      = 2'd0;
        cfg_ftw_start = 32'hDEAD_0000;
        cfg_valid     = 1'b1;
      end
      tick();
      check("rp_ftw", dbg_ftw, rp_ftw[i]);
      check("rp_done", sweep_done, (i == 2) || (i == 6));
      check("rp_state", dbg_state, ST_SWEEP);
      check("rp_ready", cfg_ready, 0);
    end
    cfg_valid = 1'b0;

    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;

    // Start above stop: immediate saturation and done pulse
    send_cfg(2'd1, 32'h500, 32'h400, 32'h100, 16'd0, 32'h0, 1'b1);
    check("ge_ftw", dbg_ftw, 32'h400);
    check("ge_done", sweep_done, 1);
    check("ge_state", dbg_state, ST_HOLD);
    check("ge_busy", busy, 0);
    tick();
    check("ge_done_clear", sweep_done, 0);
    check("ge_ftw_after", dbg_ftw, 32'h400);
    check("ge_valid", phase_valid, 1);

    // Zero step behaves as fixed, then mode 3 also as fixed
    send_cfg(2'd2, 32'h0100_0000, 32'h400, 32'h0, 16'd0, 32'h0, 1'b1);
    check("z_state", dbg_state, ST_FIXED);
    check("z_busy", busy, 1);
    check("z_ready", cfg_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("z_phase", phase_out, k * 4);
      check("z_ftw", dbg_ftw, 32'h0100_0000);
      check("z_done", sweep_done, 0);
    end
    send_cfg(2'd3, 32'h0200_0000, 32'h0800_0000, 32'h100, 16'd0, 32'h0, 1'b0);
    check("m3_state", dbg_state, ST_FIXED);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("m3_phase", phase_out, 12 + k * 8);
      check("m3_ftw", dbg_ftw, 32'h0200_0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_phase_gen.md
# dds_phase_gen

Phase-generation stage of the DDS datapath, feeding the sine look-up stage. It holds a phase accumulator and a frequency tuning word (FTW) with either a fixed value or a programmable linear upward sweep (chirp). Each accumulate cycle it emits a registered, offset-adjusted LUT phase address. Configuration comes through a valid/ready handshake from the control logic in `top`.

## Interface
- `ACC_W`, 32, accumulator and FTW width
- `ADDR_W`, 10, phase address width (MSBs of accumulator)
- `DWELL_W`, 16, dwell counter width
- `CLK` input 1 system clock (single-ended, after differential input buffer)
- `RST_N` input 1 asynchronous active-low reset
- `run` input 1 enable; low freezes accumulator, sweep and dwell count
- `cfg_valid` input 1 configuration offered
- `cfg_ready` output 1 configuration can be accepted
- `cfg_mode` input 2 0 = fixed, 1 = single sweep, 2 = repeating sweep, 3 = treated as 0
- `cfg_ftw_start` input ACC_W fixed FTW, or sweep start FTW
- `cfg_ftw_stop` input ACC_W sweep end FTW
- `cfg_ftw_step` input ACC_W sweep increment
- `cfg_dwell` input DWELL_W extra cycles per sweep step; a step lasts dwell+1 active cycles
- `cfg_phase_off` input ACC_W phase offset added before address truncation
- `cfg_phase_rst` input 1 clear accumulator on accept
- `phase_out` output ADDR_W LUT address
- `phase_valid` output 1 phase_out is a new sample
- `sweep_done` output 1 one-cycle pulse when the FTW reaches the stop value
- `busy` output 1 state is FIXED or SWEEP

## Operation
- States: IDLE, FIXED, SWEEP, HOLD.
- Reset values: state IDLE; acc, ftw, offset and dwell count 0; `phase_out` 0; `phase_valid` 0; `sweep_done` 0; `busy` 0; `cfg_ready` 1.
- `cfg_ready` = 1 in IDLE, FIXED and HOLD. It is 0 in SWEEP, so a sweep cannot be retuned; it must finish, or reset.
- Accept (`cfg_valid && cfg_ready`) at edge t:
  - latch ftw ← start, offset ← phase_off, dwell count ← 0.
  - if `cfg_phase_rst`, acc ← 0; otherwise acc is kept (phase-continuous retune).
  - next state: FIXED for mode 0/3 or for step = 0; otherwise SWEEP.
  - sweep with start ≥ stop: ftw ← stop, `sweep_done` pulses next cycle, then behaves as if the end was reached.
- Active cycle (`run`=1, state FIXED/SWEEP/HOLD):
  - phase_out ← (acc + offset)[ACC_W-1 -: ADDR_W]
  - acc ← acc + ftw, modulo 2^ACC_W, wrapping silently
  - `phase_valid` ← 1
- In IDLE, or with `run`=0: `phase_valid` ← 0 and all state is held. `phase_out` holds its last value.
- SWEEP step rule, on each active cycle:
  - if dwell count = cfg_dwell: count ← 0, and ftw ← min(ftw + step, stop), computed ACC_W+1 wide so overflow saturates to stop.
  - otherwise count increments.
- When the new ftw equals stop:
  - `sweep_done` pulses high in the cycle after the update edge.
  - mode 1: go to HOLD, keep accumulating at the stop FTW.
  - mode 2: ftw ← start after one full dwell period at stop, stay in SWEEP, `sweep_done` pulses again on each arrival at stop.
- HOLD behaves like FIXED. A new accept leaves it.
- Asynchronous reset mid-operation returns everything to the reset values immediately. The first sample after reset release requires a new configuration.

## Timing
- Config accepted at edge t. First sample at edge t+1: `phase_valid`=1 and `phase_out` = top bits of (acc_t + offset). With `cfg_phase_rst`, that is top bits of offset.
- Steady state: one sample per active cycle, throughput 1.
- FTW change at edge e affects `phase_out` from edge e+2.
- `run` falling at edge e: `phase_valid` is 0 after e and there is no accumulate at e. `run` rising: the next edge produces a sample from the frozen acc.
- The accept cycle itself is not an accumulate cycle, even if `run`=1.

## Test plan
- Reset: assert `RST_N`=0 asynchronously mid-cycle → all outputs 0 at once, `cfg_ready`=1. Release, no config → `phase_valid` stays 0.
- Fixed mode: ftw=0x0100_0000, offset 0, phase_rst, run=1 → `phase_out` 0, 4, 8, … 1020, then wraps to 0 on sample 257. `busy`=1, `sweep_done` never pulses.
- Offset: same setup, offset=0x8000_0000 → first `phase_out` is 512, then 516. Retune without phase_rst to ftw=0x0200_0000 → increments of 8 with no phase jump.
- Single sweep: start=0x100, stop=0x400, step=0x100, dwell=1 → ftw is 0x100, 0x200, 0x300, 0x400, each for 2 active cycles. One `sweep_done` pulse, state HOLD, `cfg_ready` back to 1, `busy`=0.
- Repeating sweep with saturation: start=0, stop=0x250, step=0x100, dwell=0 → ftw 0, 0x100, 0x200, 0x250, then 0 again. `sweep_done` pulses every 4 cycles. `cfg_valid` during the sweep is not accepted.
- Freeze and edge cases:
  - `run`=0 for 5 cycles mid-sweep → `phase_valid`=0 and acc, ftw and dwell count unchanged; the sweep resumes exactly.
  - start=0x500 > stop=0x400 → ftw=0x400 and an immediate `sweep_done`.
  - step=0 → fixed behaviour.
